// File: rtl/mips_pipe_pkg.sv
// Shared types and encodings for the MIPS pipeline MEM stage.
// State enum, RegDst/MemToReg encodings and the bus word-address helper.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC4 = 2'd2;

  localparam int unsigned RA_INDEX_DEFAULT = 31;
  localparam int unsigned TIMEOUT_W        = 8;

  // The bus is word-only: the low two address bits are always dropped.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Load/store bus sequencer for the MEM stage: state, bus registers, load latch, stall.
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without ack.
module mem_bus_fsm
  import mips_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             bus_ack_i,
  input  logic [31:0]      bus_rdata_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [31:0]      bus_addr_o,
  output logic [31:0]      bus_wdata_o,
  output logic [31:0]      load_data_o,
  output mem_state_e       state_o,
  output logic             stall_o,
  output logic             bus_error_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  mem_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic        memop;

  assign memop = mem_read_i | mem_write_i;

`ifdef MEM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = word_addr(addr_i);
          wdata_d = wdata_i;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ACCESS: begin
        if (bus_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          // A combined read+write is treated as a store; nothing is loaded.
          if (!we_q) load_d = bus_rdata_i;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_error_o = err_q;
`else
  assign bus_error_o = 1'b0;
`endif

  // DONE releases the stall so the held instruction retires without re-issuing.
  assign stall_o = ~reset & (((state_q == IDLE) & memop) | (state_q == ACCESS));

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign load_data_o = load_q;
  assign state_o     = state_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs loads/stores on a req/ack bus and registers the result toward WB.
// Define MEM_TIMEOUT_EN to enable the ACCESS timeout and oBusError abort pulse.
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned RA_INDEX       = RA_INDEX_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iPC_plus_4,
  input  logic [4:0]  iInstRt,
  input  logic [4:0]  iInstRd,
  input  logic [31:0] iRegReadData2,
  input  logic [1:0]  iRegDst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [1:0]  iMemToReg,
  input  logic        iRegWrite,
  input  logic [31:0] iALUOut,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic        oStall,
  output logic        oBusError,
  output logic [31:0] oWbPC_plus_4,
  output logic [4:0]  oWbWriteAddr,
  output logic [31:0] oWbWriteData,
  output logic        oWbRegWrite
);

  mem_state_e  bus_state;
  logic [31:0] load_data;
  logic [4:0]  wb_addr_d;
  logic [31:0] wb_data_d;

  logic [31:0] wb_pc_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        wb_regwrite_q;

  mem_bus_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_read_i  (iMemRead),
    .mem_write_i (iMemWrite),
    .addr_i      (iALUOut),
    .wdata_i     (iRegReadData2),
    .bus_ack_i   (iBusAck),
    .bus_rdata_i (iBusRData),
    .bus_req_o   (oBusReq),
    .bus_we_o    (oBusWe),
    .bus_addr_o  (oBusAddr),
    .bus_wdata_o (oBusWData),
    .load_data_o (load_data),
    .state_o     (bus_state),
    .stall_o     (oStall),
    .bus_error_o (oBusError)
  );

  always_comb begin
    wb_addr_d = iInstRt;
    case (iRegDst)
      REGDST_RD: wb_addr_d = iInstRd;
      REGDST_RA: wb_addr_d = 5'(RA_INDEX);
      default:   wb_addr_d = iInstRt;
    endcase
  end

  // Load data only exists in DONE; a MemToReg=1 with no completed access writes 0.
  always_comb begin
    wb_data_d = iALUOut;
    case (iMemToReg)
      MEMTOREG_MEM: wb_data_d = (bus_state == DONE) ? load_data : 32'h0;
      MEMTOREG_PC4: wb_data_d = iPC_plus_4;
      default:      wb_data_d = iALUOut;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_pc_q       <= '0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      wb_regwrite_q <= 1'b0;
    end else if (oStall) begin
      wb_regwrite_q <= 1'b0;
    end else begin
      wb_pc_q       <= iPC_plus_4;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      // Writes to $zero and aborted accesses retire as bubbles.
      wb_regwrite_q <= iRegWrite & (wb_addr_d != 5'd0) & ~oBusError;
    end
  end

  assign oWbPC_plus_4 = wb_pc_q;
  assign oWbWriteAddr = wb_addr_q;
  assign oWbWriteData = wb_data_q;
  assign oWbRegWrite  = wb_regwrite_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed plan items plus random instructions.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout abort path.
module tb_mem_access_stage;

  localparam int TO = 4;
  localparam int W  = 69;

  logic        clk;
  logic        reset;
  logic [31:0] iPC_plus_4;
  logic [4:0]  iInstRt;
  logic [4:0]  iInstRd;
  logic [31:0] iRegReadData2;
  logic [1:0]  iRegDst;
  logic        iMemRead;
  logic        iMemWrite;
  logic [1:0]  iMemToReg;
  logic        iRegWrite;
  logic [31:0] iALUOut;
  logic        oBusReq;
  logic        oBusWe;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic        iBusAck;
  logic [31:0] iBusRData;
  logic        oStall;
  logic        oBusError;
  logic [31:0] oWbPC_plus_4;
  logic [4:0]  oWbWriteAddr;
  logic [31:0] oWbWriteData;
  logic        oWbRegWrite;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  mem_access_stage #(
    .RA_INDEX       (31),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .iPC_plus_4    (iPC_plus_4),
    .iInstRt       (iInstRt),
    .iInstRd       (iInstRd),
    .iRegReadData2 (iRegReadData2),
    .iRegDst       (iRegDst),
    .iMemRead      (iMemRead),
    .iMemWrite     (iMemWrite),
    .iMemToReg     (iMemToReg),
    .iRegWrite     (iRegWrite),
    .iALUOut       (iALUOut),
    .oBusReq       (oBusReq),
    .oBusWe        (oBusWe),
    .oBusAddr      (oBusAddr),
    .oBusWData     (oBusWData),
    .iBusAck       (iBusAck),
    .iBusRData     (iBusRData),
    .oStall        (oStall),
    .oBusError     (oBusError),
    .oWbPC_plus_4  (oWbPC_plus_4),
    .oWbWriteAddr  (oWbWriteAddr),
    .oWbWriteData  (oWbWriteData),
    .oWbRegWrite   (oWbRegWrite)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_dest(input logic [1:0] regdst, input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (regdst == 2'd1) return rd;
    if (regdst == 2'd2) return 5'd31;
    return rt;
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] m2r, input logic [31:0] alu,
                                           input logic [31:0] rdata, input logic [31:0] pc);
    if (m2r == 2'd1) return rdata;
    if (m2r == 2'd2) return pc;
    return alu;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // k = ACCESS cycle carrying the ack (1..); k = 0 on a memory op means no ack at all.
  task automatic issue(input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] d2, input logic [1:0] regdst, input logic mr,
                       input logic mw, input logic [1:0] m2r, input logic rw,
                       input logic [31:0] alu, input int k, input logic [31:0] rdata);
    logic       memop;
    logic       timed_out;
    int         acc;
    int         n;
    logic [4:0] dest;
    logic       ack_cycle;
    memop     = mr | mw;
    timed_out = memop && (k == 0);
    acc       = timed_out ? TO : k;
    n         = memop ? acc + 2 : 1;
    dest      = ref_dest(regdst, rt, rd);
    if (rw && dest != 5'd0 && !timed_out)
      exp_q.push_back({pc, dest, ref_data(m2r, alu, rdata, pc)});
    iPC_plus_4 = pc; iInstRt = rt; iInstRd = rd; iRegReadData2 = d2; iRegDst = regdst;
    iMemRead = mr; iMemWrite = mw; iMemToReg = m2r; iRegWrite = rw; iALUOut = alu;
    for (int c = 0; c < n; c++) begin
      ack_cycle = memop && (k != 0) && (c == k);
      if (ack_cycle) begin
        iBusAck = 1'b1; iBusRData = rdata;
      end else if (memop && c >= 1 && c <= acc) begin
        iBusAck = 1'b0; iBusRData = $urandom;
      end else begin
        iBusAck = 1'($urandom_range(0, 1)); iBusRData = $urandom;
      end
      #2;
      check("stall", oStall, memop && c <= acc);
      check("bus_req", oBusReq, memop && c >= 1 && c <= acc);
      check("bus_error", oBusError, timed_out && c == acc + 1);
      if (memop && c >= 1 && c <= acc) begin
        check("bus_addr", oBusAddr, alu & 32'hFFFF_FFFC);
        check("bus_we", oBusWe, mw);
        if (mw) check("bus_wdata", oBusWData, d2);
      end
      @(posedge clk); #1;
    end
    iBusAck = 1'b0;
  endtask

  task automatic zero_inputs();
    iPC_plus_4 = '0; iInstRt = '0; iInstRd = '0; iRegReadData2 = '0; iRegDst = '0;
    iMemRead = 1'b0; iMemWrite = 1'b0; iMemToReg = '0; iRegWrite = 1'b0; iALUOut = '0;
    iBusAck = 1'b0; iBusRData = '0;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_wb_pc"}, oWbPC_plus_4, 0);
    check({tag, "_wb_addr"}, oWbWriteAddr, 0);
    check({tag, "_wb_data"}, oWbWriteData, 0);
    check({tag, "_wb_rw"}, oWbRegWrite, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && oWbRegWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got write addr %0d data %0h expected no write (t=%0t)",
                 oWbWriteAddr, oWbWriteData, $time);
      end else begin
        e = exp_q.pop_front();
        check("wb_pc", oWbPC_plus_4, e[68:37]);
        check("wb_addr", oWbWriteAddr, e[36:32]);
        check("wb_data", oWbWriteData, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sel;
    logic [1:0]  m2r;
    logic        mr, mw;
    int          tmp;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    zero_inputs();
    #12;
    check("rst_bus_req", oBusReq, 0);
    check("rst_bus_we", oBusWe, 0);
    check("rst_bus_addr", oBusAddr, 0);
    check("rst_bus_wdata", oBusWData, 0);
    check("rst_stall", oStall, 0);
    check("rst_bus_error", oBusError, 0);
    check_wb_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU op, load with 3-cycle wait, store with immediate ack
    issue(32'h0000_0100, 5'd0, 5'd5, 32'h0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 32'h1234, 0, 32'h0);
    issue(32'h0000_0104, 5'd8, 5'd3, 32'h0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 3, 32'hDEADBEEF);
    issue(32'h0000_0108, 5'd9, 5'd0, 32'hCAFEF00D, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h23, 1, 32'h0);
    // read+write together behaves as a store
    issue(32'h0000_010C, 5'd4, 5'd7, 32'h1111_2222, 2'd1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0000_0087, 2,
          32'h5555_AAAA);
    // jal-type, then a write to $zero
    issue(32'h0040_0008, 5'd2, 5'd6, 32'h0, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 32'h7777, 0, 32'h0);
    issue(32'h0040_000C, 5'd0, 5'd6, 32'h0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h8888, 0, 32'h0);
    issue(32'h0040_0010, 5'd1, 5'd6, 32'h0, 2'd3, 1'b0, 1'b0, 2'd3, 1'b1, 32'h9999, 0, 32'h0);

    // reset in the 2nd ACCESS cycle of a load
    iPC_plus_4 = 32'h200; iInstRt = 5'd8; iInstRd = 5'd0; iRegDst = 2'd0; iMemRead = 1'b1;
    iMemWrite = 1'b0; iMemToReg = 2'd1; iRegWrite = 1'b1; iALUOut = 32'h40; iBusAck = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_before_rst", oBusReq, 1);
    reset = 1'b1;
    #1;
    check("async_rst_req", oBusReq, 0);
    check("async_rst_stall", oStall, 0);
    check("async_rst_addr", oBusAddr, 0);
    check_wb_zero("async_rst");
    zero_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    iBusAck = 1'b1; iBusRData = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    iBusAck = 1'b0;
    check("late_ack_req", oBusReq, 0);
    check("late_ack_stall", oStall, 0);
    check_wb_zero("late_ack");
    @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
    issue(32'h0000_0300, 5'd10, 5'd0, 32'h0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0044, 0, 32'h0);
    issue(32'h0000_0304, 5'd0, 5'd11, 32'h0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 32'hABCD, 0, 32'h0);
`else
    issue(32'h0000_0300, 5'd10, 5'd0, 32'h0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0044, 20,
          32'h0123_4567);
`endif

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      sel = 2'($urandom_range(0, 3));
      mr  = (sel == 2'd1) || (sel == 2'd3);
      mw  = (sel == 2'd2) || (sel == 2'd3);
      if (sel == 2'd1) begin
        m2r = 2'($urandom_range(0, 3));
      end else begin
        tmp = $urandom_range(0, 2);
        m2r = (tmp == 1) ? 2'd3 : 2'(tmp);
      end
      issue($urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom,
            2'($urandom_range(0, 3)), mr, mw, m2r, 1'($urandom_range(0, 1)), $urandom,
            (mr | mw) ? $urandom_range(1, TO) : 0, $urandom);
    end

    zero_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs and runs load/store transactions on a req/ack data bus with arbitrary wait states.
- Raises a pipeline stall while a transaction is outstanding.
- Resolves the writeback destination and data, and registers the result toward the WB stage, folding in the MEM/WB register.

Parameters:
- RA_INDEX, 31, register index written when RegDst=2 (jal).
- TIMEOUT_CYCLES, 255, ACCESS cycles without ack before abort (MEM_TIMEOUT_EN only); legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- iPC_plus_4  in  32  from EX/MEM
- iInstRt  in  5  from EX/MEM
- iInstRd  in  5  from EX/MEM
- iRegReadData2  in  32  store data
- iRegDst  in  2  0=Rt, 1=Rd, 2=RA_INDEX, 3=Rt
- iMemRead  in  1  load request
- iMemWrite  in  1  store request
- iMemToReg  in  2  0=ALUOut, 1=load data, 2=PC+4, 3=ALUOut
- iRegWrite  in  1  writeback enable
- iALUOut  in  32  memory address / ALU result
- oBusReq  out  1  bus request
- oBusWe  out  1  1=write
- oBusAddr  out  32  word address {iALUOut[31:2],2'b00}
- oBusWData  out  32  store data
- iBusAck  in  1  transaction-complete pulse
- iBusRData  in  32  read data, valid with iBusAck
- oStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- oBusError  out  1  one-cycle abort pulse
- oWbPC_plus_4  out  32  registered
- oWbWriteAddr  out  5  registered destination register
- oWbWriteData  out  32  registered writeback data
- oWbRegWrite  out  1  registered write enable

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE immediately, even mid-transaction.
  - oBusReq, oBusWe, oBusError, oWbRegWrite drop to 0 immediately.
  - All 32/5-bit outputs clear to 0.
- memop = iMemRead | iMemWrite. When both are high, write wins: oBusWe=1 and no load data is captured.
- FSM states and transitions:
  - IDLE: memop=1 goes to ACCESS; otherwise stays IDLE.
  - ACCESS: iBusAck=1 goes to DONE; otherwise stays ACCESS.
  - DONE: always returns to IDLE.
- Bus signals:
  - oBusReq, oBusWe, oBusAddr, oBusWData are registered.
  - They are loaded on the IDLE->ACCESS edge and held stable throughout ACCESS.
  - oBusReq clears on the ACCESS->DONE edge.
  - The load data latch captures iBusRData on the ack edge.
- iBusAck outside ACCESS is ignored.
- oStall (combinational) = (IDLE & memop) | ACCESS. It is low in DONE, so the held instruction retires without re-triggering.
- WB register, updated every edge:
  - When oStall=1: oWbRegWrite<=0 (bubble); other WB outputs may update freely.
  - When oStall=0: oWbPC_plus_4<=iPC_plus_4.
  - oWbWriteAddr<=dest selected by iRegDst.
  - oWbWriteData<=source selected by iMemToReg; MemToReg=1 uses the latched load data in DONE.
  - oWbRegWrite<=iRegWrite & (dest!=0).
- Latency:
  - Non-memory instruction: 1 cycle to WB outputs.
  - Memory instruction with ack in the k-th ACCESS cycle: stall for k+1 cycles; WB valid after the DONE edge (k+2 cycles).
- Address bits [1:0] are ignored; word access only.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without ack.
  - When count==TIMEOUT_CYCLES-1 with no ack: drop oBusReq, go to DONE, pulse oBusError for the DONE cycle, force the retiring oWbRegWrite=0.
  - An ack in the same cycle as expiry wins, with normal completion.
- Not defined: oBusError is tied 0 and ACCESS waits indefinitely.

Decomposition:
- Shared package mips_pipe_pkg:
  - state enum {IDLE, ACCESS, DONE}.
  - RegDst encodings REGDST_RT/RD/RA.
  - MemToReg encodings MEMTOREG_ALU/MEM/PC4.
  - Default RA index 31.
  - Timeout counter width 8.
- One natural sub-module, mem_bus_fsm: state register, bus output registers, load latch, timeout counter, oStall/oBusError.
- The top level holds the dest/data muxes and the WB register.

Test Plan:
- ALU op (iMemRead=0, iMemWrite=0, iRegWrite=1, iRegDst=1, iInstRd=5, iALUOut=32'h1234) -> next edge: oWbWriteAddr=5, oWbWriteData=32'h1234, oWbRegWrite=1; oStall stays 0.
- Load at 32'h0000_0010, iBusAck on 3rd ACCESS cycle with iBusRData=32'hDEADBEEF, iMemToReg=1, iRegDst=0, iInstRt=8 -> oStall high 4 cycles; oBusReq high 3 cycles with addr 32'h10, oBusWe=0; then oWbWriteData=32'hDEADBEEF, oWbWriteAddr=8, oWbRegWrite=1 exactly once.
- Store (iMemWrite=1, iALUOut=32'h23, iRegReadData2=32'hCAFEF00D), ack on 1st ACCESS cycle -> oBusAddr=32'h20, oBusWe=1, oBusWData=32'hCAFEF00D; 2 stall cycles; iRegWrite=0 gives oWbRegWrite=0.
- jal-type (iRegDst=2, iMemToReg=2, iPC_plus_4=32'h0040_0008); also iRegDst=0 with iInstRt=0 -> first gives addr 31, data 32'h00400008; second gives oWbRegWrite=0.
- Reset asserted in the 2nd ACCESS cycle of a load -> oBusReq and oStall drop without a clock edge; a later ack is ignored; WB outputs stay 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> oBusReq high 4 cycles, oBusError pulses 1 cycle, oWbRegWrite=0, FSM returns to IDLE; the following instruction proceeds normally.
